// File: rtl/sm_input_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm_input_filter_pkg
// Purpose  : Shared limits for the switch/button input conditioner.
// Revision : 1.0
// ============================================================================
package sm_input_filter_pkg;

   localparam int unsigned MIN_SYNC_STAGES   = 2;
   localparam int unsigned MIN_STABLE_CYCLES = 1;

   // Largest acceptance count a CNT_W-bit counter can represent.
   function automatic longint max_stable_cycles(input int cnt_w);
      return longint'(1) << cnt_w;
   endfunction

endpackage : sm_input_filter_pkg
`default_nettype wire

// File: rtl/sm_filter_channel.sv
`default_nettype none
// ============================================================================
// Module   : sm_filter_channel
// Purpose  : One input bit: synchroniser, stability counter, edge pulses.
// Revision : 1.0
// ============================================================================
module sm_filter_channel
   import sm_input_filter_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter int   CNT_W         = 16,
   parameter int   STABLE_CYCLES = 1000,
   parameter logic RESET_VAL     = 1'b0,
   parameter bit   BYPASS        = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall,
   output logic edge_next
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s;
   logic                   q_q;
   logic                   q_d;
   logic                   rise_q;
   logic                   rise_d;
   logic                   fall_q;
   logic                   fall_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
      s      = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   generate
      if (BYPASS) begin : g_bypass
         logic tick_unused;
         assign tick_unused = tick;

         always_comb begin
            q_d = s;
         end
      end else begin : g_filter
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Any return to the accepted level throws away partial progress.
         always_comb begin
            cnt_d = cnt_q;
            q_d   = q_q;
            if (s == q_q) begin
               cnt_d = '0;
            end else if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  q_d   = s;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_comb begin
      rise_d    = q_d & ~q_q;
      fall_d    = ~q_d & q_q;
      edge_next = rise_d | fall_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule : sm_filter_channel
`default_nettype wire

// File: rtl/sm_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : sm_input_filter
// Purpose  : Multi-channel debounced input conditioner with edge pulses.
// Revision : 1.0
// ============================================================================
module sm_input_filter
   import sm_input_filter_pkg::*;
#(
   parameter int               WIDTH         = 1,
   parameter int               SYNC_STAGES   = 2,
   parameter int               CNT_W         = 16,
   parameter int               STABLE_CYCLES = 1000,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0,
   parameter bit               BYPASS        = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   generate
      if ((STABLE_CYCLES < int'(MIN_STABLE_CYCLES)) ||
          (longint'(STABLE_CYCLES) > max_stable_cycles(CNT_W)) ||
          (SYNC_STAGES < int'(MIN_SYNC_STAGES))) begin : g_param_error
         $error("sm_input_filter: illegal STABLE_CYCLES/CNT_W/SYNC_STAGES combination");
      end
   endgenerate

   logic [WIDTH-1:0] edge_next;
   logic             changed_q;
   logic             changed_d;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_chan
         sm_filter_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[i]),
            .BYPASS        (BYPASS)
         ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .d         (d[i]),
            .q         (q[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .edge_next (edge_next[i])
         );
      end
   endgenerate

   // Registered from the same next-state edges so it lines up with rise/fall.
   always_comb begin
      changed_d = |edge_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= changed_d;
      end
   end

   assign changed = changed_q;

endmodule : sm_input_filter
`default_nettype wire

// File: tb/tb_sm_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_input_filter
// Purpose  : Scoreboard bench for four sm_input_filter configurations.
// Revision : 1.0
// ============================================================================
module tb_sm_input_filter;

   typedef struct packed {
      logic [3:0] q;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       chg;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_a;
   logic       tick_c;
   logic [3:0] d;

   logic [3:0] q_o    [4];
   logic [3:0] rise_o [4];
   logic [3:0] fall_o [4];
   logic       chg_o  [4];

   exp_t       sb     [4][$];
   logic [3:0] m_pipe [4][$];
   logic [3:0] m_q    [4];
   int         m_run  [4][4];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   // A: filtered, STABLE=4; B: bypass, 3 sync stages; C: full-range 2-bit counter; D: STABLE=1
   sm_input_filter #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(16), .STABLE_CYCLES(4),
                     .RESET_VAL(4'b1010), .BYPASS(1'b0)) u_a (
      .clk(clk), .rst(rst), .tick(tick_a), .d(d),
      .q(q_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .changed(chg_o[0]));

   sm_input_filter #(.WIDTH(4), .SYNC_STAGES(3), .CNT_W(16), .STABLE_CYCLES(1000),
                     .RESET_VAL(4'b0000), .BYPASS(1'b1)) u_b (
      .clk(clk), .rst(rst), .tick(tick_c), .d(d),
      .q(q_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .changed(chg_o[1]));

   sm_input_filter #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(2), .STABLE_CYCLES(4),
                     .RESET_VAL(4'b0110), .BYPASS(1'b0)) u_c (
      .clk(clk), .rst(rst), .tick(tick_c), .d(d),
      .q(q_o[2]), .rise(rise_o[2]), .fall(fall_o[2]), .changed(chg_o[2]));

   sm_input_filter #(.WIDTH(4), .SYNC_STAGES(4), .CNT_W(1), .STABLE_CYCLES(1),
                     .RESET_VAL(4'b1111), .BYPASS(1'b0)) u_d (
      .clk(clk), .rst(rst), .tick(tick_c), .d(d),
      .q(q_o[3]), .rise(rise_o[3]), .fall(fall_o[3]), .changed(chg_o[3]));

   function automatic int sync_of(input int k);
      case (k)
         0: return 2;
         1: return 3;
         2: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int stable_of(input int k);
      case (k)
         0: return 4;
         1: return 1000;
         2: return 4;
         default: return 1;
      endcase
   endfunction

   function automatic logic [3:0] rv_of(input int k);
      case (k)
         0: return 4'b1010;
         1: return 4'b0000;
         2: return 4'b0110;
         default: return 4'b1111;
      endcase
   endfunction

   // Reference: the sampled level is d delayed by the synchroniser depth; a new
   // level is accepted once it has been seen on STABLE qualifying ticks in a row.
   task automatic model_step(input int k, input logic r, input logic tk, input logic [3:0] din);
      exp_t       e;
      logic [3:0] s;
      logic [3:0] nq;
      int         ns;
      ns = sync_of(k);
      if (r) begin
         m_pipe[k].delete();
         repeat (ns) m_pipe[k].push_back(rv_of(k));
         m_q[k] = rv_of(k);
         for (int i = 0; i < 4; i++) m_run[k][i] = 0;
         e.q    = rv_of(k);
         e.rise = 4'b0;
         e.fall = 4'b0;
         e.chg  = 1'b0;
      end else begin
         s = m_pipe[k][ns-1];
         m_pipe[k].push_front(din);
         void'(m_pipe[k].pop_back());
         nq = m_q[k];
         for (int i = 0; i < 4; i++) begin
            if (k == 1) begin
               nq[i] = s[i];
            end else if (s[i] == m_q[k][i]) begin
               m_run[k][i] = 0;
            end else if (tk) begin
               m_run[k][i] = m_run[k][i] + 1;
               if (m_run[k][i] == stable_of(k)) begin
                  nq[i]       = s[i];
                  m_run[k][i] = 0;
               end
            end
         end
         e.rise = nq & ~m_q[k];
         e.fall = ~nq & m_q[k];
         e.chg  = |(e.rise | e.fall);
         e.q    = nq;
         m_q[k] = nq;
      end
      sb[k].push_back(e);
   endtask

   task automatic drive(input logic r, input logic ta, input logic tc, input logic [3:0] din);
      @(negedge clk);
      rst    = r;
      tick_a = ta;
      tick_c = tc;
      d      = din;
      for (int k = 0; k < 4; k++) model_step(k, r, (k == 0) ? ta : tc, din);
      @(posedge clk);
      #2;
      cyc++;
   endtask

   // Monitor: every cycle each DUT presents a result; compare with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 4; k++) begin
            if (sb[k].size() > 0) begin
               e = sb[k].pop_front();
               n_cmp++;
               if ({q_o[k], rise_o[k], fall_o[k], chg_o[k]} !== {e.q, e.rise, e.fall, e.chg}) begin
                  n_bad++;
                  $display("FAIL dut%0d cyc%0d: got q=%b rise=%b fall=%b chg=%b, want q=%b rise=%b fall=%b chg=%b",
                           k, cyc, q_o[k], rise_o[k], fall_o[k], chg_o[k], e.q, e.rise, e.fall, e.chg);
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] dv;
      int         first_a;
      int         first_b;
      logic       ta;
      logic       tc;
      logic       r;
      rst    = 1'b1;
      tick_a = 1'b0;
      tick_c = 1'b0;
      d      = 4'b0;

      repeat (3) drive(1'b1, 1'b0, 1'b1, 4'b0000);
      drive(1'b0, 1'b1, 1'b1, 4'b0000);
      repeat (22) drive(1'b0, 1'b1, 1'b1, 4'b1010);

      // Clean step on bit 0: measure latency independently of the scoreboard.
      first_a = 0;
      first_b = 0;
      for (int n = 1; n <= 20; n++) begin
         drive(1'b0, 1'b1, 1'b1, 4'b1011);
         if (first_a == 0 && q_o[0][0] === 1'b1) first_a = n;
         if (first_b == 0 && q_o[1][0] === 1'b1) first_b = n;
      end
      n_cmp++;
      if (first_a != 6) begin
         n_bad++;
         $display("FAIL latency_filtered: got %0d cycles, want 6", first_a);
      end
      n_cmp++;
      if (first_b != 4) begin
         n_bad++;
         $display("FAIL latency_bypass: got %0d cycles, want 4", first_b);
      end

      // Bounce on bit 2: high 3, low 1, then steady high.
      repeat (3) drive(1'b0, 1'b1, 1'b1, 4'b1111);
      drive(1'b0, 1'b1, 1'b1, 4'b1011);
      repeat (20) drive(1'b0, 1'b1, 1'b1, 4'b1111);

      // Prescaled tick on C/D while bit 2 falls.
      for (int n = 0; n < 40; n++) drive(1'b0, 1'b1, (n % 4) == 0, 4'b1011);

      // Reset in the middle of a count on bit 3.
      repeat (5) drive(1'b0, 1'b1, 1'b1, 4'b0011);
      repeat (2) drive(1'b1, 1'b1, 1'b1, 4'b0011);
      repeat (15) drive(1'b0, 1'b1, 1'b1, 4'b0011);

      // Randomised phase: sparse bit flips, irregular ticks, rare resets.
      dv = 4'b0011;
      for (int n = 0; n < 2500; n++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(9) == 0) dv[i] = ~dv[i];
         ta = ($urandom_range(7) != 0);
         tc = (n < 1250) ? ((n % 4) == 0) : ($urandom_range(1) == 1);
         r  = ($urandom_range(399) == 0);
         drive(r, ta, tc, dv);
      end
      repeat (2) drive(1'b0, 1'b1, 1'b1, dv);

      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (sb[k].size() != 0) begin
            n_bad++;
            $display("FAIL drain dut%0d: got %0d pending, want 0", k, sb[k].size());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_sm_input_filter
`default_nettype wire
